axis_reg_pipe: RTL
==================

// Module: axis_reg_pipe
// PURPOSE
//  Parametrised AXI4-Stream register pipeline: STAGES cascaded slices, each a pass-through, forward or skid register.
//  Next generation of the single-stage axis_reg; used for timing closure on long datapath/SLR-crossing routes.
//  Lossless, order-preserving; full throughput in every mode.
// PARAMETERS
//  DATA_WIDTH   128  tdata width (bits)
//  KEEP_ENABLE  0    1: carry tkeep; 0: m tkeep driven all-ones
//  KEEP_WIDTH   1    tkeep width
//  LAST_ENABLE  1    1: carry tlast; 0: m tlast driven 1
//  ID_ENABLE    0    1: carry tid; 0: m tid driven 0
//  ID_WIDTH     1    tid width
//  DEST_ENABLE  0    1: carry tdest; 0: m tdest driven 0
//  DEST_WIDTH   1    tdest width
//  USER_ENABLE  0    1: carry tuser; 0: m tuser driven 0
//  USER_WIDTH   1    tuser width
//  STAGES       2    number of slices, 0..16; 0 = pure wires
//  REG_TYPE     2    0 BYPASS, 1 FWD (data/valid registered, tready combinational), 2 SKID (all registered)
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-high
//  s_axis_ifc  ifc  -   ifc_axis slave side (tdata,tkeep,tvalid,tready,tlast,tid,tdest,tuser)
//  m_axis_ifc  ifc  -   ifc_axis master side, same signals
//  stat_beats  out  32  output handshakes count (AXIS_REG_PIPE_STATS_EN only)
//  stat_stalls out  32  cycles with m tvalid & !m tready (AXIS_REG_PIPE_STATS_EN only)
// BEHAVIOUR
//  Reset: all stage valid regs, skid regs, counters = 0; m tvalid = 0; s tready = 0 during rst (SKID),
//   = 1 from first cycle after rst deasserts; in-flight beats discarded on reset mid-stream.
//  Latency: STAGES cycles for FWD/SKID (s handshake at edge N -> m tvalid visible after edge N+STAGES-1); 0 for BYPASS/STAGES=0.
//  Handshake: beat transfers on tvalid & tready at posedge; tvalid never drops, payload never changes while stalled.
//  FWD stage: s_tready = m_tready | ~valid_q; load when s_tvalid & s_tready.
//  SKID stage FSM (out reg O, skid reg K; s_tready = registered ~K_valid):
//   EMPTY: in beat -> O, go FULL.
//   FULL : in & out same cycle -> O replaced, stay; in only -> K, go SKID; out only -> EMPTY.
//   SKID : s_tready=0; out -> O<=K, go FULL.
//  Capacity: SKID holds 2 beats/stage, FWD 1; after stall of m tready, s tready falls in <=1 cycle (SKID) or same cycle (FWD).
//  Simultaneous in/out at full: no loss, no bubble; sustained 1 beat/clk with tready held high.
//  Disabled sidebands: not registered (synthesis removes), output constants as per PARAMETERS.
//  STAGES=0 or REG_TYPE=0: m <= s combinationally incl. tready.
// CONFIGURATION
//  AXIS_REG_PIPE_STATS_EN defined: stat_beats/stat_stalls ports + 32-bit counters, wrap 2^32-1 -> 0, cleared by rst.
//  Undefined: ports absent, no counter logic; datapath identical.
// STRUCTURE
//  axis_reg_pkg: reg_type_e enum {REG_BYPASS=0, REG_FWD=1, REG_SKID=2}, skid_state_e {EMPTY,FULL,SKID}, MAX_STAGES=16.
//  Sub-module axis_reg_stage: one slice (REG_TYPE select, packed payload bus); top generates STAGES instances in a chain.
//  Payload packed into one vector {tuser,tdest,tid,tlast,tkeep,tdata} of enabled fields only.
// TESTING
//  1 STAGES=2 SKID, tready=1, 64 sequential beats -> output identical order, first out 2 cycles after first in, 1 beat/clk.
//  2 Random tvalid/tready (50%), 20000 beats, tlast on last -> bit-exact match, no drop/dup, tlast on beat 20000 only.
//  3 Fill then hold m tready=0 16 cycles -> m payload stable, s tready=0 after 2*STAGES beats accepted (SKID).
//  4 Assert rst for 1 cycle mid-packet -> m tvalid=0 next cycle, s tready=0 during rst, stream restarts cleanly.
//  5 STAGES=0 and REG_TYPE=0 -> m == s same cycle, m tready drives s tready; REG_TYPE=1 -> 1-cycle latency, full rate.
//  6 STATS_EN, 100 beats with 37 stall cycles -> stat_beats=100, stat_stalls=37; preload 2^32-1 -> wraps to 0.

Source files
------------

// File: rtl/axis_reg_pkg.sv
// Shared types for the AXI4-Stream register pipeline.
// Slice kinds, skid FSM states and the stage-count limit.
package axis_reg_pkg;

   typedef enum logic [1:0] {
      REG_BYPASS = 2'd0,
      REG_FWD    = 2'd1,
      REG_SKID   = 2'd2
   } reg_type_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } skid_state_e;

   localparam int MAX_STAGES = 16;

endpackage

// File: rtl/ifc_axis.sv
// AXI4-Stream bundle with master and slave views.
// Widths are set per instance.
interface ifc_axis #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = 1,
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport master (
      output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/axis_reg_stage.sv
// One pipeline slice on a packed payload bus.
// Bypass, forward register or two-entry skid register.
module axis_reg_stage
   import axis_reg_pkg::*;
#(
   parameter int        WIDTH    = 8,
   parameter reg_type_e REG_TYPE = REG_SKID
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   if (REG_TYPE == REG_SKID) begin : g_skid
      skid_state_e      state_q;
      skid_state_e      state_d;
      logic [WIDTH-1:0] o_q;
      logic [WIDTH-1:0] k_q;
      logic             o_load_s;
      logic             o_load_k;
      logic             k_load;
      logic             in_hs;
      logic             out_hs;

      // ready comes straight from the state register
      assign s_ready = (state_q != SKID) & ~rst;
      assign m_valid = (state_q != EMPTY);
      assign m_data  = o_q;
      assign in_hs   = s_valid & s_ready;
      assign out_hs  = m_valid & m_ready;

      always_ff @(posedge clk) begin
         if (rst) state_q <= EMPTY;
         else     state_q <= state_d;
      end

      always_ff @(posedge clk) begin
         if (o_load_s)      o_q <= s_data;
         else if (o_load_k) o_q <= k_q;
         if (k_load)        k_q <= s_data;
      end

      always_comb begin
         state_d  = state_q;
         o_load_s = 1'b0;
         o_load_k = 1'b0;
         k_load   = 1'b0;
         unique case (state_q)
            EMPTY: begin
               if (in_hs) begin
                  o_load_s = 1'b1;
                  state_d  = FULL;
               end
            end
            FULL: begin
               if (in_hs && out_hs) begin
                  o_load_s = 1'b1;
               end else if (in_hs) begin
                  k_load  = 1'b1;
                  state_d = SKID;
               end else if (out_hs) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_hs) begin
                  o_load_k = 1'b1;
                  state_d  = FULL;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end else if (REG_TYPE == REG_FWD) begin : g_fwd
      logic             valid_q;
      logic [WIDTH-1:0] data_q;

      assign s_ready = m_ready | ~valid_q;
      assign m_valid = valid_q;
      assign m_data  = data_q;

      always_ff @(posedge clk) begin
         if (rst)          valid_q <= 1'b0;
         else if (s_ready) valid_q <= s_valid;
      end

      always_ff @(posedge clk) begin
         if (s_valid & s_ready) data_q <= s_data;
      end
   end else begin : g_bypass
      logic unused_clk;

      assign unused_clk = ^{clk, rst};
      assign s_ready    = m_ready;
      assign m_valid    = s_valid;
      assign m_data     = s_data;
   end

endmodule

// File: rtl/axis_reg_pipe.sv
// AXI4-Stream register pipeline: STAGES chained slices.
// Define AXIS_REG_PIPE_STATS_EN for beat/stall counters.
module axis_reg_pipe
   import axis_reg_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int KEEP_ENABLE = 0,
   parameter int KEEP_WIDTH  = 1,
   parameter int LAST_ENABLE = 1,
   parameter int ID_ENABLE   = 0,
   parameter int ID_WIDTH    = 1,
   parameter int DEST_ENABLE = 0,
   parameter int DEST_WIDTH  = 1,
   parameter int USER_ENABLE = 0,
   parameter int USER_WIDTH  = 1,
   parameter int STAGES      = 2,
   parameter int REG_TYPE    = 2
) (
   input  logic        clk,
   input  logic        rst,
   ifc_axis.slave      s_axis_ifc,
   ifc_axis.master     m_axis_ifc
`ifdef AXIS_REG_PIPE_STATS_EN
   ,
   output logic [31:0] stat_beats,
   output logic [31:0] stat_stalls
`endif
);

   localparam int KW = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 0;
   localparam int LW = (LAST_ENABLE != 0) ? 1 : 0;
   localparam int IW = (ID_ENABLE != 0) ? ID_WIDTH : 0;
   localparam int DW = (DEST_ENABLE != 0) ? DEST_WIDTH : 0;
   localparam int UW = (USER_ENABLE != 0) ? USER_WIDTH : 0;
   localparam int KO = DATA_WIDTH;
   localparam int LO = KO + KW;
   localparam int IO = LO + LW;
   localparam int DO = IO + IW;
   localparam int UO = DO + DW;
   localparam int PW = UO + UW;

   logic [PW-1:0] s_pl;
   logic [PW-1:0] m_pl;
   logic          m_valid;
   logic          unused_side;

   // disabled sidebands are simply dropped here
   assign unused_side = ^{s_axis_ifc.tkeep, s_axis_ifc.tlast,
                          s_axis_ifc.tid, s_axis_ifc.tdest,
                          s_axis_ifc.tuser};

   assign s_pl[DATA_WIDTH-1:0] = s_axis_ifc.tdata;
   assign m_axis_ifc.tdata     = m_pl[DATA_WIDTH-1:0];
   assign m_axis_ifc.tvalid    = m_valid;

   if (KEEP_ENABLE != 0) begin : g_keep
      assign s_pl[KO +: KEEP_WIDTH] = s_axis_ifc.tkeep;
      assign m_axis_ifc.tkeep       = m_pl[KO +: KEEP_WIDTH];
   end else begin : g_no_keep
      assign m_axis_ifc.tkeep = '1;
   end

   if (LAST_ENABLE != 0) begin : g_last
      assign s_pl[LO]         = s_axis_ifc.tlast;
      assign m_axis_ifc.tlast = m_pl[LO];
   end else begin : g_no_last
      assign m_axis_ifc.tlast = 1'b1;
   end

   if (ID_ENABLE != 0) begin : g_id
      assign s_pl[IO +: ID_WIDTH] = s_axis_ifc.tid;
      assign m_axis_ifc.tid       = m_pl[IO +: ID_WIDTH];
   end else begin : g_no_id
      assign m_axis_ifc.tid = '0;
   end

   if (DEST_ENABLE != 0) begin : g_dest
      assign s_pl[DO +: DEST_WIDTH] = s_axis_ifc.tdest;
      assign m_axis_ifc.tdest       = m_pl[DO +: DEST_WIDTH];
   end else begin : g_no_dest
      assign m_axis_ifc.tdest = '0;
   end

   if (USER_ENABLE != 0) begin : g_user
      assign s_pl[UO +: USER_WIDTH] = s_axis_ifc.tuser;
      assign m_axis_ifc.tuser       = m_pl[UO +: USER_WIDTH];
   end else begin : g_no_user
      assign m_axis_ifc.tuser = '0;
   end

   if (STAGES == 0 || REG_TYPE == int'(REG_BYPASS)) begin : g_wire
      logic unused_clk;

      assign unused_clk        = ^{clk, rst};
      assign m_pl              = s_pl;
      assign m_valid           = s_axis_ifc.tvalid;
      assign s_axis_ifc.tready = m_axis_ifc.tready;
   end else begin : g_chain
      logic [PW-1:0] pl  [STAGES+1];
      logic          vld [STAGES+1];
      logic          rdy [STAGES+1];

      assign pl[0]             = s_pl;
      assign vld[0]            = s_axis_ifc.tvalid;
      assign s_axis_ifc.tready = rdy[0];
      assign m_pl              = pl[STAGES];
      assign m_valid           = vld[STAGES];
      assign rdy[STAGES]       = m_axis_ifc.tready;

      for (genvar i = 0; i < STAGES; i++) begin : g_stage
         axis_reg_stage #(
            .WIDTH    (PW),
            .REG_TYPE (reg_type_e'(REG_TYPE))
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .s_data  (pl[i]),
            .s_valid (vld[i]),
            .s_ready (rdy[i]),
            .m_data  (pl[i+1]),
            .m_valid (vld[i+1]),
            .m_ready (rdy[i+1])
         );
      end
   end

`ifdef AXIS_REG_PIPE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_beats  <= '0;
         stat_stalls <= '0;
      end else begin
         if (m_valid & m_axis_ifc.tready)
            stat_beats <= stat_beats + 32'd1;
         if (m_valid & ~m_axis_ifc.tready)
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule
